// File: rtl/accel_pkg.sv
// accel_pkg: shared constants, FSM state encoding and sample helpers for the
// ADXL362 SPI reader.
package accel_pkg;

    localparam logic [7:0] CMD_WRITE     = 8'h0A;
    localparam logic [7:0] CMD_READ      = 8'h0B;
    localparam logic [7:0] REG_POWER_CTL = 8'h2D;
    localparam logic [7:0] PWR_MEASURE   = 8'h02;
    localparam logic [7:0] REG_XDATA     = 8'h08;

    typedef enum logic [2:0] {
        ST_INIT_WAIT,
        ST_INIT_XFER,
        ST_CS_GAP,
        ST_IDLE,
        ST_READ_XFER,
        ST_UPDATE
    } state_t;

    // Two's-complement negate that maps -128 to +127 instead of wrapping.
    function automatic logic [7:0] sat_neg8(input logic [7:0] v);
        return (v == 8'h80) ? 8'h7F : (~v + 8'd1);
    endfunction

    // MOSI byte for position idx of the init write (is_read=0) or the burst read.
    function automatic logic [7:0] xfer_byte(input logic is_read, input logic [1:0] idx);
        logic [7:0] b;
        b = 8'h00;
        if (is_read) begin
            case (idx)
                2'd0:    b = CMD_READ;
                2'd1:    b = REG_XDATA;
                default: b = 8'h00;
            endcase
        end else begin
            case (idx)
                2'd0:    b = CMD_WRITE;
                2'd1:    b = REG_POWER_CTL;
                default: b = PWR_MEASURE;
            endcase
        end
        return b;
    endfunction

    // Mean of four signed bytes: 10-bit sum, arithmetic shift right by two.
    function automatic logic [7:0] avg4(input logic [7:0] a, input logic [7:0] b,
                                        input logic [7:0] c, input logic [7:0] d);
        logic [9:0] s;
        s = {{2{a[7]}}, a} + {{2{b[7]}}, b} + {{2{c[7]}}, c} + {{2{d[7]}}, d};
        return s[9:2];
    endfunction

endpackage

// File: rtl/spi_byte_shifter.sv
// spi_byte_shifter: mode-0 SPI engine for one byte. A start accepted in the
// cycle that done is high chains the next byte with no gap on SCLK.
module spi_byte_shifter #(
    parameter int SCLK_HALF = 50
) (
    input  logic       clk,
    input  logic       arst,
    input  logic       start,
    input  logic [7:0] tx_byte,
    input  logic       i_miso,
    output logic       o_sclk,
    output logic       o_mosi,
    output logic [7:0] rx_byte,
    output logic       done,
    output logic       busy
);

    localparam int             HW        = $clog2(SCLK_HALF);
    localparam logic [HW-1:0]  HALF_LAST = HW'(SCLK_HALF - 1);

    logic          busy_q, busy_d;
    logic          sclk_q, sclk_d;
    logic          mosi_q, mosi_d;
    logic [HW-1:0] half_q, half_d;
    logic [2:0]    bit_q, bit_d;
    logic [6:0]    shift_q, shift_d;
    logic [7:0]    rx_q, rx_d;
    logic          half_end;

    assign half_end = (half_q == HALF_LAST);
    // done marks the cycle before the final falling edge, when rx_q is complete.
    assign done     = busy_q && sclk_q && half_end && (bit_q == 3'd7);

    // Half-period timing, MISO capture on rising edges, MOSI advance on falling edges.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
        busy_d  = busy_q;
        sclk_d  = sclk_q;
        mosi_d  = mosi_q;
        half_d  = half_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        rx_d    = rx_q;
        if (busy_q) begin
            if (half_end) begin
                half_d = '0;
                sclk_d = ~sclk_q;
                if (!sclk_q) begin
                    rx_d = {rx_q[6:0], i_miso};
                end else if (bit_q != 3'd7) begin
                    bit_d   = bit_q + 3'd1;
                    mosi_d  = shift_q[6];
                    shift_d = {shift_q[5:0], 1'b0};
                end else begin
                    busy_d = 1'b0;
                    mosi_d = 1'b0;
                end
            end else begin
                half_d = half_q + 1'b1;
            end
        end
        if (start && (!busy_q || done)) begin
            busy_d  = 1'b1;
            sclk_d  = 1'b0;
            half_d  = '0;
            bit_d   = '0;
            mosi_d  = tx_byte[7];
            shift_d = tx_byte[6:0];
        end
    end

    // State registers; reset drives SCLK low immediately.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            busy_q  <= 1'b0;
            sclk_q  <= 1'b0;
            mosi_q  <= 1'b0;
            half_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            rx_q    <= '0;
        end else begin
            // NOTE: non-blocking so every flop samples the pre-edge values.
            busy_q  <= busy_d;
            sclk_q  <= sclk_d;
            mosi_q  <= mosi_d;
            half_q  <= half_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            rx_q    <= rx_d;
        end
    end

    assign o_sclk  = sclk_q;
    assign o_mosi  = mosi_q;
    assign rx_byte = rx_q;
    assign busy    = busy_q;

endmodule

// File: rtl/accel_spi_reader.sv
// accel_spi_reader: ADXL362 SPI master. Writes measurement mode once, then
// burst-reads XDATA/YDATA every SAMPLE_PERIOD cycles and holds the samples.
// Build option: define ACCEL_AVG_EN to average the last four samples per axis.
module accel_spi_reader
    import accel_pkg::*;
#(
    parameter int SCLK_HALF     = 50,
    parameter int SAMPLE_PERIOD = 100000,
    parameter bit INVERT_X      = 1'b1,
    parameter bit INVERT_Y      = 1'b0
) (
    input  logic       clk,
    input  logic       arst,
    output logic       o_spi_sclk,
    output logic       o_spi_mosi,
    input  logic       i_spi_miso,
    output logic       o_spi_cs_n,
    output logic [7:0] o_accel_x,
    output logic [7:0] o_accel_y,
    output logic       o_valid,
    output logic       o_init_done
);

    localparam int            CW        = $clog2(SAMPLE_PERIOD + 1);
    localparam logic [CW-1:0] WAIT_LAST = CW'(SAMPLE_PERIOD - 1);
    localparam logic [CW-1:0] GAP_LAST  = CW'(2 * SCLK_HALF - 1);
    localparam logic [CW-1:0] TAIL_LAST = CW'(SCLK_HALF - 1);

    state_t        state_q, state_d;
    logic          cs_n_q, cs_n_d;
    logic [1:0]    byte_q, byte_d;
    logic [CW-1:0] wait_q, wait_d;
    logic [CW-1:0] timer_q, timer_d;
    logic [7:0]    x_raw_q, x_raw_d;
    logic [7:0]    y_raw_q, y_raw_d;
    logic [7:0]    accel_x_q, accel_x_d;
    logic [7:0]    accel_y_q, accel_y_d;
    logic          valid_q, valid_d;
    logic          init_done_q, init_done_d;

    logic          shift_start, shift_done, shift_busy;
    logic [7:0]    shift_tx, shift_rx;
    logic          is_read;
    logic [1:0]    last_idx;
    logic [7:0]    x_post, y_post;

    assign x_post = INVERT_X ? sat_neg8(x_raw_q) : x_raw_q;
    assign y_post = INVERT_Y ? sat_neg8(y_raw_q) : y_raw_q;

    spi_byte_shifter #(.SCLK_HALF(SCLK_HALF)) u_shifter (
        .clk     (clk),
        .arst    (arst),
        .start   (shift_start),
        .tx_byte (shift_tx),
        .i_miso  (i_spi_miso),
        .o_sclk  (o_spi_sclk),
        .o_mosi  (o_spi_mosi),
        .rx_byte (shift_rx),
        .done    (shift_done),
        .busy    (shift_busy)
    );

`ifdef ACCEL_AVG_EN
    logic [7:0] hist_x_q [3];
    logic [7:0] hist_x_d [3];
    logic [7:0] hist_y_q [3];
    logic [7:0] hist_y_d [3];

    // Sample history of the three previous post-inversion samples per axis.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            // NOTE: this small history is reset on purpose so early averages start from 0.
            for (int i = 0; i < 3; i++) begin
                hist_x_q[i] <= '0;
                hist_y_q[i] <= '0;
            end
        end else begin
            hist_x_q <= hist_x_d;
            hist_y_q <= hist_y_d;
        end
    end
`endif

    // Transaction sequencing, sample timer and output update.
    always_comb begin
        state_d     = state_q;
        cs_n_d      = cs_n_q;
        byte_d      = byte_q;
        wait_d      = wait_q;
        x_raw_d     = x_raw_q;
        y_raw_d     = y_raw_q;
        accel_x_d   = accel_x_q;
        accel_y_d   = accel_y_q;
        valid_d     = 1'b0;
        init_done_d = init_done_q;
        shift_start = 1'b0;
        shift_tx    = 8'h00;
        is_read     = (state_q == ST_READ_XFER);
        last_idx    = is_read ? 2'd3 : 2'd2;
`ifdef ACCEL_AVG_EN
        hist_x_d    = hist_x_q;
        hist_y_d    = hist_y_q;
`endif
        if (init_done_q) begin
            timer_d = (timer_q == WAIT_LAST) ? '0 : timer_q + 1'b1;
        end else begin
            timer_d = '0;
        end

        case (state_q)
            ST_INIT_WAIT: begin
                if (wait_q == WAIT_LAST) begin
                    state_d     = ST_INIT_XFER;
                    wait_d      = '0;
                    cs_n_d      = 1'b0;
                    byte_d      = '0;
                    shift_start = 1'b1;
                    shift_tx    = xfer_byte(1'b0, 2'd0);
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end
            ST_INIT_XFER, ST_READ_XFER: begin
                if (shift_done) begin
                    if (is_read && byte_q == 2'd2) x_raw_d = shift_rx;
                    if (is_read && byte_q == 2'd3) y_raw_d = shift_rx;
                    if (byte_q != last_idx) begin
                        byte_d      = byte_q + 2'd1;
                        shift_start = 1'b1;
                        shift_tx    = xfer_byte(is_read, byte_q + 2'd1);
                    end
                end else if (!shift_busy) begin
                    // Shifter idle after the last byte: hold CS low for the trailing half period.
                    if (wait_q == TAIL_LAST) begin
                        cs_n_d  = 1'b1;
                        wait_d  = '0;
                        state_d = is_read ? ST_UPDATE : ST_CS_GAP;
                    end else begin
                        wait_d = wait_q + 1'b1;
                    end
                end
            end
            ST_CS_GAP: begin
                if (wait_q == GAP_LAST) begin
                    wait_d      = '0;
                    init_done_d = 1'b1;
                    state_d     = ST_IDLE;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end
            ST_IDLE: begin
                if (timer_q == '0) begin
                    state_d     = ST_READ_XFER;
                    cs_n_d      = 1'b0;
                    byte_d      = '0;
                    shift_start = 1'b1;
                    shift_tx    = xfer_byte(1'b1, 2'd0);
                end
            end
            ST_UPDATE: begin
                valid_d = 1'b1;
`ifdef ACCEL_AVG_EN
                accel_x_d   = avg4(x_post, hist_x_q[0], hist_x_q[1], hist_x_q[2]);
                accel_y_d   = avg4(y_post, hist_y_q[0], hist_y_q[1], hist_y_q[2]);
                hist_x_d[0] = x_post;
                hist_x_d[1] = hist_x_q[0];
                hist_x_d[2] = hist_x_q[1];
                hist_y_d[0] = y_post;
                hist_y_d[1] = hist_y_q[0];
                hist_y_d[2] = hist_y_q[1];
`else
                accel_x_d = x_post;
                accel_y_d = y_post;
`endif
                wait_d  = '0;
                state_d = ST_CS_GAP;
            end
            default: state_d = ST_INIT_WAIT;
        endcase
    end

    // Control and output registers; reset raises CS and clears outputs immediately.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            state_q     <= ST_INIT_WAIT;
            cs_n_q      <= 1'b1;
            byte_q      <= '0;
            wait_q      <= '0;
            timer_q     <= '0;
            x_raw_q     <= '0;
            y_raw_q     <= '0;
            accel_x_q   <= '0;
            accel_y_q   <= '0;
            valid_q     <= 1'b0;
            init_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cs_n_q      <= cs_n_d;
            byte_q      <= byte_d;
            wait_q      <= wait_d;
            timer_q     <= timer_d;
            x_raw_q     <= x_raw_d;
            y_raw_q     <= y_raw_d;
            accel_x_q   <= accel_x_d;
            accel_y_q   <= accel_y_d;
            valid_q     <= valid_d;
            init_done_q <= init_done_d;
        end
    end

    assign o_spi_cs_n  = cs_n_q;
    assign o_accel_x   = accel_x_q;
    assign o_accel_y   = accel_y_q;
    assign o_valid     = valid_q;
    assign o_init_done = init_done_q;

endmodule

// File: tb/tb_accel_spi_reader.sv
// tb_accel_spi_reader: SPI slave model plus scoreboard for accel_spi_reader.
// Expected samples are pushed when a read window opens and popped on o_valid.
module tb_accel_spi_reader;

    localparam int SH    = 4;
    localparam int SP    = 2000;
    localparam bit INV_X = 1'b1;
    localparam bit INV_Y = 1'b0;
    localparam int NTBL  = 14;

    localparam logic [7:0] TBL_X [NTBL] = '{8'h10, 8'h80, 8'hD8, 8'hD8, 8'hD8, 8'hD8, 8'h7F,
                                            8'h81, 8'h33, 8'hD8, 8'hD8, 8'hD8, 8'hD8, 8'h00};
    localparam logic [7:0] TBL_Y [NTBL] = '{8'hF0, 8'h80, 8'h28, 8'h28, 8'h28, 8'h28, 8'h01,
                                            8'h7F, 8'h44, 8'h28, 8'h28, 8'h28, 8'h28, 8'h81};
    localparam logic [7:0] INIT_B [3] = '{8'h0A, 8'h2D, 8'h02};
    localparam logic [7:0] READ_B [2] = '{8'h0B, 8'h08};

    typedef struct {
        logic [7:0] x;
        logic [7:0] y;
    } exp_t;

    logic       clk  = 1'b0;
    logic       arst = 1'b1;
    logic       miso = 1'b0;
    logic       sclk, mosi, cs_n, valid, init_done;
    logic [7:0] accel_x, accel_y;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    accel_spi_reader #(
        .SCLK_HALF     (SH),
        .SAMPLE_PERIOD (SP),
        .INVERT_X      (INV_X),
        .INVERT_Y      (INV_Y)
    ) dut (
        .clk         (clk),
        .arst        (arst),
        .o_spi_sclk  (sclk),
        .o_spi_mosi  (mosi),
        .i_spi_miso  (miso),
        .o_spi_cs_n  (cs_n),
        .o_accel_x   (accel_x),
        .o_accel_y   (accel_y),
        .o_valid     (valid),
        .o_init_done (init_done)
    );

    task automatic check(input string tag, input int got, input int exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, exp);
        end
    endtask

    function automatic int to_s8(input logic [7:0] b);
        return b[7] ? int'(b) - 256 : int'(b);
    endfunction

    function automatic int neg_sat(input int v);
        if (v == -128) return 127;
        return -v;
    endfunction

    function automatic int floor4(input int s);
        if (s >= 0) return s / 4;
        return -((-s + 3) / 4);
    endfunction

    // Monitor / slave / scoreboard state (written only by the monitor process).
    exp_t       exp_q [$];
    logic [7:0] win_bytes [$];
    logic [7:0] sr;
    logic [31:0] frame;
    int  cyc = 0, tbl_idx = 0, n_valid = 0, n_init = 0;
    int  win_rises = 0, cs_fall_cyc = 0, cs_rise_cyc = 0, last_rise_cyc = 0, last_fall_cyc = 0;
    int  bad_period = 0, prev_read_fall = -1, init_rise_cyc = 0, unstable = 0, pulse_err = 0;
    int  hx [3], hy [3];
    bit  in_win = 0, win_is_init = 0, expect_init = 1, init_pending = 0, end_done = 0;
    bit  arst_prev = 0;
    logic prev_cs = 1'b1, prev_sclk = 1'b0, prev_valid = 1'b0, prev_init_done = 1'b0;
    logic [7:0] prev_x = 8'h00, prev_y = 8'h00;

    // Written only by the stimulus process.
    int  timeouts = 0;
    bit  end_req = 0;

    always begin
        @(negedge clk or posedge arst);
        if (arst && !arst_prev) begin
            arst_prev = 1'b1;
            #1;
            check("rst_cs_n", int'(cs_n), 1);
            check("rst_sclk", int'(sclk), 0);
            check("rst_accel_x", int'(accel_x), 0);
            check("rst_accel_y", int'(accel_y), 0);
            check("rst_valid", int'(valid), 0);
            check("rst_init_done", int'(init_done), 0);
        end
        if (arst) begin
            in_win = 0;
            win_bytes.delete();
            exp_q.delete();
            expect_init = 1;
            init_pending = 0;
            prev_read_fall = -1;
            for (int i = 0; i < 3; i++) begin
                hx[i] = 0;
                hy[i] = 0;
            end
            miso = 1'b0;
            prev_cs = 1'b1;
            prev_sclk = 1'b0;
            prev_valid = 1'b0;
            prev_init_done = 1'b0;
            prev_x = 8'h00;
            prev_y = 8'h00;
        end else begin
            arst_prev = 1'b0;
            cyc++;
            // Window open: choose init or read, push the expected read result.
            if (prev_cs && !cs_n) begin
                in_win = 1;
                win_rises = 0;
                win_bytes.delete();
                sr = 8'h00;
                bad_period = 0;
                cs_fall_cyc = cyc;
                if (expect_init) begin
                    win_is_init = 1;
                    frame = 32'h0;
                end else begin
                    exp_t e;
                    int   px, py, ex, ey, k;
                    win_is_init = 0;
                    k = (tbl_idx < NTBL) ? tbl_idx : NTBL - 1;
                    tbl_idx++;
                    frame = {8'hA5, 8'h5A, TBL_X[k], TBL_Y[k]};
                    px = INV_X ? neg_sat(to_s8(TBL_X[k])) : to_s8(TBL_X[k]);
                    py = INV_Y ? neg_sat(to_s8(TBL_Y[k])) : to_s8(TBL_Y[k]);
`ifdef ACCEL_AVG_EN
                    ex = floor4(px + hx[0] + hx[1] + hx[2]);
                    ey = floor4(py + hy[0] + hy[1] + hy[2]);
                    hx[2] = hx[1]; hx[1] = hx[0]; hx[0] = px;
                    hy[2] = hy[1]; hy[1] = hy[0]; hy[0] = py;
`else
                    ex = px;
                    ey = py;
`endif
                    e.x = 8'(ex);
                    e.y = 8'(ey);
                    exp_q.push_back(e);
                    if (prev_read_fall >= 0) check("read_spacing", cyc - prev_read_fall, SP);
                    prev_read_fall = cyc;
                end
                miso = frame[31];
            end
            // SCLK edges inside the window: capture MOSI on rise, advance MISO on fall.
            if (in_win && !cs_n) begin
                if (!prev_sclk && sclk) begin
                    if (win_rises == 0) check("cs_to_first_sclk", cyc - cs_fall_cyc, SH);
                    else if (cyc - last_rise_cyc != 2 * SH) bad_period++;
                    last_rise_cyc = cyc;
                    sr = {sr[6:0], mosi};
                    win_rises++;
                    if (win_rises % 8 == 0) win_bytes.push_back(sr);
                end else if (prev_sclk && !sclk) begin
                    last_fall_cyc = cyc;
                    miso = (win_rises < 32) ? frame[31 - win_rises] : 1'b0;
                end
            end
            // Window close: check framing and captured MOSI bytes.
            if (in_win && !prev_cs && cs_n) begin
                in_win = 0;
                miso = 1'b0;
                cs_rise_cyc = cyc;
                check("last_sclk_to_cs", cyc - last_fall_cyc, SH);
                check("sclk_period", bad_period, 0);
                if (win_is_init) begin
                    check("init_nbytes", win_bytes.size(), 3);
                    check("init_rises", win_rises, 24);
                    for (int i = 0; i < 3; i++)
                        check($sformatf("init_byte%0d", i),
                              (i < win_bytes.size()) ? int'(win_bytes[i]) : -1, int'(INIT_B[i]));
                    check("init_done_low_at_cs", int'(init_done), 0);
                    expect_init = 0;
                    init_pending = 1;
                    init_rise_cyc = cyc;
                    n_init++;
                end else begin
                    check("read_rises", win_rises, 32);
                    for (int i = 0; i < 2; i++)
                        check($sformatf("read_byte%0d", i),
                              (i < win_bytes.size()) ? int'(win_bytes[i]) : -1, int'(READ_B[i]));
                end
            end
            // Output pulse: pop the scoreboard.
            if (valid) begin
                n_valid++;
                if (prev_valid) pulse_err++;
                if (exp_q.size() == 0) begin
                    check("valid_unexpected", 1, 0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("accel_x", int'(accel_x), int'(e.x));
                    check("accel_y", int'(accel_y), int'(e.y));
                    check("valid_latency", cyc - cs_rise_cyc, 1);
                end
            end else if (accel_x !== prev_x || accel_y !== prev_y) begin
                unstable++;
            end
            if (init_done && !prev_init_done) begin
                check("init_done_delay", init_pending ? cyc - init_rise_cyc : -1, 2 * SH);
                init_pending = 0;
            end
            if (prev_init_done && !init_done) unstable++;
            if (end_req && !end_done) begin
                check("outputs_stable", unstable, 0);
                check("valid_one_cycle", pulse_err, 0);
                check("valid_count", n_valid, 13);
                check("init_windows", n_init, 2);
                check("scoreboard_empty", exp_q.size(), 0);
                check("no_timeouts", timeouts, 0);
                end_done = 1;
            end
            prev_cs = cs_n;
            prev_sclk = sclk;
            prev_valid = valid;
            prev_init_done = init_done;
            prev_x = accel_x;
            prev_y = accel_y;
        end
    end

    initial begin
        repeat (3) @(negedge clk);
        #1 arst = 1'b0;

        // Eight reads after the init write.
        for (int i = 0; i < 25000 && n_valid < 8; i++) @(negedge clk);
        if (n_valid < 8) timeouts++;

        // Reset mid read, after 6 rising and 6 falling SCLK edges.
        for (int i = 0; i < 5000 && !(in_win && !win_is_init && win_rises == 6 && !sclk); i++)
            @(negedge clk);
        if (!(in_win && !win_is_init && win_rises == 6)) timeouts++;
        #1 arst = 1'b1;
        repeat (2) @(negedge clk);
        #1 arst = 1'b0;

        // Init write again, then five more reads.
        for (int i = 0; i < 25000 && n_valid < 13; i++) @(negedge clk);
        if (n_valid < 13) timeouts++;

        end_req = 1;
        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
